// File: rtl/gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// gray_conv_arbiter
//
// One registered binary/Gray conversion engine shared by NUM_REQ requesters.
// A round-robin arbiter picks one request per cycle. The converted word is
// returned one cycle later on a single response slot, tagged with the
// requester id and the conversion mode.
//
// Parameters:
//   N        data width in bits (>=1)
//   NUM_REQ  number of requesters (>=1)
//   ID_W     requester id width, max(1, clog2(NUM_REQ))
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  per-requester request valid            [NUM_REQ]
//   req_ready  per-requester accept, one-hot or zero   [NUM_REQ]
//   req_data   flattened words, requester i at [i*N +: N]
//   req_mode   per-requester mode: 0 = bin->gray, 1 = gray->bin
//   rsp_valid  response slot holds a result
//   rsp_ready  consumer accepts the response
//   rsp_data   converted word                          [N]
//   rsp_id     index of the requester served           [ID_W]
//   rsp_mode   mode used for this result
//
// Optional build macro GRAY_CONV_STATS_EN adds:
//   stat_clr      clears both counters (wins over increment)
//   stat_b2g_cnt  saturating count of accepted mode-0 requests [16]
//   stat_g2b_cnt  saturating count of accepted mode-1 requests [16]
// -----------------------------------------------------------------------------
module gray_conv_arbiter #(
  parameter int N       = 4,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_mode,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_mode
`ifdef GRAY_CONV_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [15:0]          stat_b2g_cnt,
  output logic [15:0]          stat_g2b_cnt
`endif
);

  function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB down; fully combinational, settles in one cycle.
  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b        = g;
    for (int k = N - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // Requester index reached k steps above the priority pointer, with wrap.
  function automatic int wrap_idx(input logic [ID_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return (s >= NUM_REQ) ? s - NUM_REQ : s;
  endfunction

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] ptr_nxt;
  logic [N-1:0]    gnt_word;
  logic            gnt_mode;
  logic            gnt_found;
  logic            slot_free;
  logic            accept;

  // Output slot can take a new result if empty or being drained this cycle.
  assign slot_free = !rsp_valid || rsp_ready;

  // NOTE: every variable gets a default before the search loop so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_word  = '0;
    gnt_mode  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_valid[wrap_idx(ptr, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(wrap_idx(ptr, k));
        gnt_word  = req_data[wrap_idx(ptr, k)*N +: N];
        gnt_mode  = req_mode[wrap_idx(ptr, k)];
      end
    end
  end

  assign accept    = rst_n && slot_free && gnt_found;
  assign req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign ptr_nxt   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_mode  <= 1'b0;
      ptr       <= '0;
    end else if (accept) begin
      // A new result replaces the slot even when it is drained this cycle,
      // giving one result per cycle back to back.
      rsp_valid <= 1'b1;
      rsp_data  <= gnt_mode ? gray2bin(gnt_word) : bin2gray(gnt_word);
      rsp_id    <= gnt_idx;
      rsp_mode  <= gnt_mode;
      ptr       <= ptr_nxt;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef GRAY_CONV_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      stat_b2g_cnt <= '0;
      stat_g2b_cnt <= '0;
    end else if (accept) begin
      if (!gnt_mode && stat_b2g_cnt != 16'hFFFF) stat_b2g_cnt <= stat_b2g_cnt + 16'd1;
      if ( gnt_mode && stat_g2b_cnt != 16'hFFFF) stat_g2b_cnt <= stat_g2b_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gray_conv_arbiter
//
// Directed self-checking bench for gray_conv_arbiter with N=4, NUM_REQ=4.
// Inputs change 1 time unit after the rising edge; outputs are compared
// after a further settle delay, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_gray_conv_arbiter;

  localparam int N       = 4;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_data;
  logic [NUM_REQ-1:0]   req_mode;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [N-1:0]         rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_mode;
`ifdef GRAY_CONV_STATS_EN
  logic                 stat_clr;
  logic [15:0]          stat_b2g_cnt;
  logic [15:0]          stat_g2b_cnt;
`endif

  int total = 0;
  int bad   = 0;

  gray_conv_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_mode  (rsp_mode)
`ifdef GRAY_CONV_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_b2g_cnt (stat_b2g_cnt),
    .stat_g2b_cnt (stat_g2b_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [N-1:0] d, input logic m);
    req_data[i*N +: N] = d;
    req_mode[i]        = m;
  endtask

  task automatic check_rsp(input string tag, input logic [N-1:0] d,
                           input logic [ID_W-1:0] id, input logic m);
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".data"},  32'(rsp_data),  32'(d));
    check({tag, ".id"},    32'(rsp_id),    32'(id));
    check({tag, ".mode"},  32'(rsp_mode),  32'(m));
  endtask

  // Round-robin stimulus: per-requester word, mode, and hand-derived result.
  logic [N-1:0] rr_data [NUM_REQ] = '{4'b0001, 4'b0110, 4'b1111, 4'b0101};
  logic         rr_mode [NUM_REQ] = '{1'b0,    1'b1,    1'b0,    1'b1};
  logic [N-1:0] rr_exp  [NUM_REQ] = '{4'b0001, 4'b0100, 4'b1000, 4'b0110};

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;  // requests present during reset must not be granted
    req_data  = '0;
    req_mode  = '0;
    rsp_ready = 1'b0;
`ifdef GRAY_CONV_STATS_EN
    stat_clr  = 1'b0;
`endif

    // ---------------- reset state ----------------
    step();
    step();
    settle();
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.data",  32'(rsp_data),  32'd0);
    check("rst.id",    32'(rsp_id),    32'd0);
    check("rst.mode",  32'(rsp_mode),  32'd0);
    check("rst.ready", 32'(req_ready), 32'd0);
`ifdef GRAY_CONV_STATS_EN
    check("rst.b2g",   32'(stat_b2g_cnt), 32'd0);
    check("rst.g2b",   32'(stat_g2b_cnt), 32'd0);
`endif
    req_valid = '0;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    step();

    // ---------------- basic bin->gray: req 2, 1011 -> 1110 ----------------
    req_valid = 4'b0100;
    set_req(2, 4'b1011, 1'b0);
    settle();
    check("b2g.ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    check_rsp("b2g", 4'b1110, 2'd2, 1'b0);

    // ---------------- gray->bin and more, all from req 0 (ptr=3) ----------------
    req_valid = 4'b0001;
    set_req(0, 4'b1111, 1'b1);
    settle();
    check("g2b1.ready", 32'(req_ready), 32'b0001);
    step();
    check_rsp("g2b1", 4'b1010, 2'd0, 1'b1);
    set_req(0, 4'b0000, 1'b1);
    step();
    check_rsp("g2b0", 4'b0000, 2'd0, 1'b1);
    set_req(0, 4'b1000, 1'b0);
    step();
    check_rsp("b2g8", 4'b1100, 2'd0, 1'b0);
    req_valid = '0;
    step();
    check("drain.valid", 32'(rsp_valid), 32'd0);

    // ptr is 1 now; serve req 3 to bring it back to 0
    req_valid = 4'b1000;
    set_req(3, 4'b0000, 1'b0);
    settle();
    check("wrap.ready", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    check_rsp("wrap", 4'b0000, 2'd3, 1'b0);

    // ---------------- round robin, all four held valid ----------------
    for (int i = 0; i < NUM_REQ; i++) set_req(i, rr_data[i], rr_mode[i]);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      settle();
      check($sformatf("rr%0d.ready", c), 32'(req_ready), 32'(1) << (c % 4));
      step();
      check_rsp($sformatf("rr%0d", c), rr_exp[c % 4], ID_W'(c % 4), rr_mode[c % 4]);
    end
    req_valid = '0;
    step();

    // ---------------- backpressure ----------------
    // req 1, bin 1010 -> gray 1111
    req_valid = 4'b0010;
    set_req(1, 4'b1010, 1'b0);
    step();
    check_rsp("bp.load", 4'b1111, 2'd1, 1'b0);
    req_valid = 4'b1000;
    set_req(3, 4'b0011, 1'b0);
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("bp%0d.ready", c), 32'(req_ready), 32'd0);
      check_rsp($sformatf("bp%0d", c), 4'b1111, 2'd1, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    settle();
    check("bp.release", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    check_rsp("bp.next", 4'b0010, 2'd3, 1'b0);

    // ---------------- reset mid-operation ----------------
    // ptr is 0; serve req 1 (gray 0011 -> bin 0010) leaving ptr=2, hold slot
    req_valid = 4'b0010;
    set_req(1, 4'b0011, 1'b1);
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    check_rsp("mid.load", 4'b0010, 2'd1, 1'b1);
    rst_n     = 1'b0;
    req_valid = 4'b1001;
    set_req(0, 4'b0111, 1'b0);
    set_req(3, 4'b1100, 1'b1);
    settle();
    check("mid.rst_ready", 32'(req_ready), 32'd0);
    step();
    check("mid.valid", 32'(rsp_valid), 32'd0);
    check("mid.data",  32'(rsp_data),  32'd0);
    check("mid.id",    32'(rsp_id),    32'd0);
    check("mid.mode",  32'(rsp_mode),  32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    settle();
    check("mid.first", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b1000;
    check_rsp("mid.r0", 4'b0100, 2'd0, 1'b0);
    settle();
    check("mid.second", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    check_rsp("mid.r3", 4'b1000, 2'd3, 1'b1);
    step();

`ifdef GRAY_CONV_STATS_EN
    // ---------------- statistics counters ----------------
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("st.clr_b2g", 32'(stat_b2g_cnt), 32'd0);
    check("st.clr_g2b", 32'(stat_g2b_cnt), 32'd0);
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      set_req(0, 4'(c), (c >= 3) ? 1'b1 : 1'b0);
      step();
    end
    req_valid = '0;
    check("st.b2g", 32'(stat_b2g_cnt), 32'd3);
    check("st.g2b", 32'(stat_g2b_cnt), 32'd2);
    req_valid = 4'b0001;
    set_req(0, 4'b0001, 1'b0);
    stat_clr  = 1'b1;
    step();
    stat_clr  = 1'b0;
    req_valid = '0;
    check("st.pri_b2g", 32'(stat_b2g_cnt), 32'd0);
    check("st.pri_g2b", 32'(stat_g2b_cnt), 32'd0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
